// File: rtl/cpu_bus_responder.sv
// Program/data bus responder: backing memories, wait states and ready pulses. Optional range check: BUS_RANGE_CHECK_EN.
// Latency: a request taken at edge k returns rdy and data at edge k+WAIT+1; one transaction per WAIT+2 cycles per port.
// Backpressure: requests are only taken in IDLE; a load_we aimed at a busy port stalls that port's FSM.
module cpu_bus_responder #(
  parameter int DATA_W    = 32,
  parameter int PROG_AW   = 10,
  parameter int DATA_AW   = 10,
  parameter int PROG_WAIT = 0,
  parameter int DATA_WAIT = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [31:0]       ADDR_Prog,
  input  logic              CS_P,
  output logic [DATA_W-1:0] Prog_BUS_READ,
  output logic              prog_rdy,
  input  logic [31:0]       ADDR,
  input  logic              CS,
  input  logic              WE,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic              data_rdy,
  input  logic              load_we,
  input  logic              load_sel,
  input  logic [15:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [DATA_W-1:0]  r_pmem [2**PROG_AW];
  logic [DATA_W-1:0]  r_dmem [2**DATA_AW];

  state_t             r_p_state;
  logic [3:0]         r_p_cnt;
  logic [PROG_AW-1:0] r_p_idx;
  logic               r_p_bad;

  state_t             r_d_state;
  logic [3:0]         r_d_cnt;
  logic [DATA_AW-1:0] r_d_idx;
  logic               r_d_we;
  logic [DATA_W-1:0]  r_d_wdata;
  logic               r_d_bad;

  logic w_p_take, w_d_take;
  logic w_p_bad, w_d_bad;
  logic w_p_freeze, w_d_freeze;
  logic w_d_commit;
  logic w_unused_load;

  assign w_p_take   = (r_p_state == S_IDLE) && CS_P;
  assign w_d_take   = (r_d_state == S_IDLE) && CS;
  assign w_p_freeze = load_we && !load_sel && (r_p_state != S_IDLE);
  assign w_d_freeze = load_we &&  load_sel && (r_d_state != S_IDLE);
  assign w_d_commit = (r_d_state == S_RESP) && r_d_we && !r_d_bad && !w_d_freeze;
  assign w_unused_load = ^load_addr;

`ifdef BUS_RANGE_CHECK_EN
  assign w_p_bad = (|ADDR_Prog[31:PROG_AW+2]) | (|ADDR_Prog[1:0]);
  assign w_d_bad = (|ADDR[31:DATA_AW+2]) | (|ADDR[1:0]);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((w_p_take && w_p_bad) || (w_d_take && w_d_bad)) begin
      err <= 1'b1;
    end
  end
`else
  logic w_unused_addr;
  assign w_p_bad = 1'b0;
  assign w_d_bad = 1'b0;
  assign err     = 1'b0;
  assign w_unused_addr = ^{ADDR_Prog[31:PROG_AW+2], ADDR_Prog[1:0], ADDR[31:DATA_AW+2], ADDR[1:0]};
`endif

  // Memories have no reset so preloaded contents survive it; a stalled port never commits alongside a load.
  always_ff @(posedge CLK) begin
    if (load_we && !load_sel) begin
      r_pmem[load_addr[PROG_AW-1:0]] <= load_data;
    end
    if (load_we && load_sel) begin
      r_dmem[load_addr[DATA_AW-1:0]] <= load_data;
    end else if (w_d_commit) begin
      r_dmem[r_d_idx] <= r_d_wdata;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_p_state     <= S_IDLE;
      r_p_cnt       <= '0;
      r_p_idx       <= '0;
      r_p_bad       <= 1'b0;
      prog_rdy      <= 1'b0;
      Prog_BUS_READ <= '0;
    end else begin
      prog_rdy <= 1'b0;
      if (!w_p_freeze) begin
        case (r_p_state)
          S_IDLE: begin
            if (CS_P) begin
              r_p_idx   <= ADDR_Prog[PROG_AW+1:2];
              r_p_bad   <= w_p_bad;
              r_p_cnt   <= 4'(PROG_WAIT);
              r_p_state <= (PROG_WAIT == 0) ? S_RESP : S_WAIT;
            end
          end
          S_WAIT: begin
            r_p_cnt <= r_p_cnt - 4'd1;
            if (r_p_cnt <= 4'd1) begin
              r_p_state <= S_RESP;
            end
          end
          S_RESP: begin
            prog_rdy      <= 1'b1;
            Prog_BUS_READ <= r_p_bad ? '0 : r_pmem[r_p_idx];
            r_p_state     <= S_IDLE;
          end
          default: r_p_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_d_state     <= S_IDLE;
      r_d_cnt       <= '0;
      r_d_idx       <= '0;
      r_d_we        <= 1'b0;
      r_d_wdata     <= '0;
      r_d_bad       <= 1'b0;
      data_rdy      <= 1'b0;
      Data_BUS_READ <= '0;
    end else begin
      data_rdy <= 1'b0;
      if (!w_d_freeze) begin
        case (r_d_state)
          S_IDLE: begin
            if (CS) begin
              r_d_idx   <= ADDR[DATA_AW+1:2];
              r_d_we    <= WE;
              r_d_wdata <= Data_BUS_WRITE;
              r_d_bad   <= w_d_bad;
              r_d_cnt   <= 4'(DATA_WAIT);
              r_d_state <= (DATA_WAIT == 0) ? S_RESP : S_WAIT;
            end
          end
          S_WAIT: begin
            r_d_cnt <= r_d_cnt - 4'd1;
            if (r_d_cnt <= 4'd1) begin
              r_d_state <= S_RESP;
            end
          end
          S_RESP: begin
            data_rdy <= 1'b1;
            // Writes leave the read bus untouched.
            if (!r_d_we) begin
              Data_BUS_READ <= r_d_bad ? '0 : r_dmem[r_d_idx];
            end
            r_d_state <= S_IDLE;
          end
          default: r_d_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: transaction-level model with due-edge bookkeeping, per-cycle compare, directed literal checks.
module tb_cpu_bus_responder;
  localparam int DW  = 32;
  localparam int PAW = 10;
  localparam int DAW = 10;
  localparam int PW  = 0;
  localparam int DWT = 2;
`ifdef BUS_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   ADDR_Prog;
  logic          CS_P;
  logic [DW-1:0] Prog_BUS_READ;
  logic          prog_rdy;
  logic [31:0]   ADDR;
  logic          CS;
  logic          WE;
  logic [DW-1:0] Data_BUS_WRITE;
  logic [DW-1:0] Data_BUS_READ;
  logic          data_rdy;
  logic          load_we;
  logic          load_sel;
  logic [15:0]   load_addr;
  logic [DW-1:0] load_data;
  logic          err;

  always #5 CLK = ~CLK;

  cpu_bus_responder #(
    .DATA_W(DW), .PROG_AW(PAW), .DATA_AW(DAW), .PROG_WAIT(PW), .DATA_WAIT(DWT)
  ) dut (
    .CLK(CLK), .reset(reset),
    .ADDR_Prog(ADDR_Prog), .CS_P(CS_P), .Prog_BUS_READ(Prog_BUS_READ), .prog_rdy(prog_rdy),
    .ADDR(ADDR), .CS(CS), .WE(WE), .Data_BUS_WRITE(Data_BUS_WRITE),
    .Data_BUS_READ(Data_BUS_READ), .data_rdy(data_rdy),
    .load_we(load_we), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a, input int aw);
    return CHK_EN && (((a >> (aw + 2)) != 32'd0) || (a[1:0] != 2'b00));
  endfunction

  function automatic logic [31:0] rand_addr(input int aw);
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'($urandom_range(0, (1 << aw) - 1)) << 2;
  endfunction

  // Reference model: each port holds at most one pending transaction with an absolute due edge.
  logic [DW-1:0]  pmem [1 << PAW];
  logic [DW-1:0]  dmem [1 << DAW];
  int unsigned    edge_n = 0;
  bit             p_pend = 1'b0, d_pend = 1'b0;
  int unsigned    p_due, d_due;
  logic [PAW-1:0] p_idx;
  logic [DAW-1:0] d_idx;
  bit             p_bad, d_bad, d_we;
  logic [DW-1:0]  d_wd;
  logic [DW-1:0]  m_pbus = '0, m_dbus = '0;
  bit             m_prdy = 1'b0, m_drdy = 1'b0, m_err = 1'b0;

  always @(posedge CLK) begin : model_step
    bit p_frz, d_frz, d_commit;
    edge_n++;
    m_prdy = 1'b0;
    m_drdy = 1'b0;
    d_commit = 1'b0;
    p_frz = load_we && !load_sel;
    d_frz = load_we && load_sel;
    if (reset) begin
      p_pend = 1'b0; d_pend = 1'b0;
      m_pbus = '0; m_dbus = '0; m_err = 1'b0;
    end else begin
      if (p_pend) begin
        if (p_frz) p_due++;
        else if (edge_n == p_due) begin
          p_pend = 1'b0;
          m_prdy = 1'b1;
          m_pbus = p_bad ? '0 : pmem[p_idx];
        end
      end else if (CS_P) begin
        p_pend = 1'b1;
        p_due  = edge_n + PW + 1;
        p_idx  = ADDR_Prog[PAW+1:2];
        p_bad  = addr_bad(ADDR_Prog, PAW);
        if (p_bad) m_err = 1'b1;
      end
      if (d_pend) begin
        if (d_frz) d_due++;
        else if (edge_n == d_due) begin
          d_pend = 1'b0;
          m_drdy = 1'b1;
          if (!d_we) m_dbus = d_bad ? '0 : dmem[d_idx];
          else if (!d_bad) d_commit = 1'b1;
        end
      end else if (CS) begin
        d_pend = 1'b1;
        d_due  = edge_n + DWT + 1;
        d_idx  = ADDR[DAW+1:2];
        d_we   = WE;
        d_wd   = Data_BUS_WRITE;
        d_bad  = addr_bad(ADDR, DAW);
        if (d_bad) m_err = 1'b1;
      end
    end
    if (load_we) begin
      if (load_sel) dmem[load_addr[DAW-1:0]] = load_data;
      else          pmem[load_addr[PAW-1:0]] = load_data;
    end
    if (d_commit) dmem[d_idx] = d_wd;
  end

  always @(posedge CLK) begin
    #1;
    chk("prog_rdy", prog_rdy, m_prdy);
    chk("prog_bus", Prog_BUS_READ, m_pbus);
    chk("data_rdy", data_rdy, m_drdy);
    chk("data_bus", Data_BUS_READ, m_dbus);
    chk("err", err, m_err);
  end

  task automatic data_txn(input bit we, input logic [31:0] a, input logic [31:0] wd, input int frz,
                          output int cnt, output int at, output logic [31:0] rd);
    cnt = 0; at = 0; rd = 'x;
    @(negedge CLK);
    CS = 1'b1; WE = we; ADDR = a; Data_BUS_WRITE = wd;
    @(negedge CLK);
    CS = 1'b0;
    if (frz > 0) begin
      load_we = 1'b1; load_sel = 1'b1; load_addr = 16'd100; load_data = $urandom;
    end
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #2;
      if (data_rdy) begin
        cnt++; at = i; rd = Data_BUS_READ;
      end
      @(negedge CLK);
      if (i >= frz) load_we = 1'b0;
    end
  endtask

  initial begin
    int cnt, at;
    logic [31:0] rd;
    CS_P = 0; ADDR_Prog = 0; CS = 0; WE = 0; ADDR = 0; Data_BUS_WRITE = 0;
    load_we = 0; load_sel = 0; load_addr = 0; load_data = 0;
    reset = 1'b1;
    // Preload every word while reset is held.
    for (int i = 0; i < 2048; i++) begin
      @(negedge CLK);
      load_we = 1'b1; load_sel = (i >= 1024); load_addr = 16'(i % 1024); load_data = $urandom;
    end
    @(negedge CLK); load_we = 1'b0;
    @(posedge CLK); #2;
    chk("rst_prog_rdy", prog_rdy, 32'd0);
    chk("rst_prog_bus", Prog_BUS_READ, 32'd0);
    chk("rst_data_rdy", data_rdy, 32'd0);
    chk("rst_data_bus", Data_BUS_READ, 32'd0);
    chk("rst_err", err, 32'd0);
    @(negedge CLK); reset = 1'b0;

    @(negedge CLK); load_we = 1'b1; load_sel = 1'b0; load_addr = 16'd5; load_data = 32'h064f;
    @(negedge CLK); load_we = 1'b0; CS_P = 1'b1; ADDR_Prog = 32'h14;
    @(negedge CLK); CS_P = 1'b0;
    @(posedge CLK); #2;
    chk("t1_prog_rdy", prog_rdy, 32'd1);
    chk("t1_prog_data", Prog_BUS_READ, 32'h064f);

    data_txn(1'b1, 32'h8, 32'h22b4, 0, cnt, at, rd);
    chk("t2_wr_rdy_count", cnt, 32'd1);
    chk("t2_wr_latency", at, 32'd3);
    data_txn(1'b0, 32'h8, 32'h0, 0, cnt, at, rd);
    chk("t2_rd_rdy_count", cnt, 32'd1);
    chk("t2_rd_latency", at, 32'd3);
    chk("t2_rd_data", rd, 32'h22b4);

    @(negedge CLK); load_we = 1'b1; load_sel = 1'b1; load_addr = 16'd4; load_data = 32'h1234;
    @(negedge CLK); load_we = 1'b0; CS = 1'b1; WE = 1'b1; ADDR = 32'h10; Data_BUS_WRITE = 32'hdeadbeef;
    @(negedge CLK); CS = 1'b0; reset = 1'b1;
    @(negedge CLK); reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(posedge CLK); #2;
      cnt += int'(data_rdy);
    end
    chk("t4_no_rdy_after_reset", cnt, 32'd0);
    data_txn(1'b0, 32'h10, 32'h0, 0, cnt, at, rd);
    chk("t4_rd_prior_data", rd, 32'h1234);

    data_txn(1'b0, 32'h8, 32'h0, 2, cnt, at, rd);
    chk("t5_frz_rdy_count", cnt, 32'd1);
    chk("t5_frz_latency", at, 32'd5);
    chk("t5_frz_data", rd, 32'h22b4);

    @(negedge CLK); load_we = 1'b1; load_sel = 1'b1; load_addr = 16'd0; load_data = 32'ha5a50001;
    @(negedge CLK); load_we = 1'b0;
    data_txn(1'b0, 32'h1000, 32'h0, 0, cnt, at, rd);
    chk("t6_range_latency", at, 32'd3);
    chk("t6_range_data", rd, CHK_EN ? 32'h0 : 32'ha5a50001);
    @(posedge CLK); #2;
    chk("t6_range_err", err, CHK_EN ? 32'd1 : 32'd0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      CS_P = ($urandom_range(0, 2) != 0);
      ADDR_Prog = rand_addr(PAW);
      CS = 1'($urandom_range(0, 1));
      WE = 1'($urandom_range(0, 1));
      ADDR = rand_addr(DAW);
      Data_BUS_WRITE = $urandom;
      load_we = ($urandom_range(0, 7) == 0);
      load_sel = 1'($urandom_range(0, 1));
      load_addr = 16'($urandom);
      load_data = $urandom;
      reset = ($urandom_range(0, 199) == 0);
    end
    @(negedge CLK);
    CS_P = 0; CS = 0; load_we = 0; reset = 0;
    repeat (20) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
